fifo_router_param: RTL and testbench
====================================

Name: fifo_router_param

Overview:
- Parametrised, packet-aware router output FIFO.
- Next generation of the router's per-port FIFO: configurable width and depth, header tagging, packet byte tracking, fill-level flags and overflow detection.
- Sits between the router's packet writer (FSM/synchroniser driving write_enb and lfd_state) and the destination-port reader.
- Storage is DEPTH entries of DATA_WIDTH+1 bits; the extra bit marks header bytes.

Parameters:
- DATA_WIDTH, 8, data byte width; must be ≥ 3.
- ADDR_WIDTH, 4, pointer width; DEPTH = 2**ADDR_WIDTH (16).
- AF_MARGIN, 2, almost_full asserts when count ≥ DEPTH-AF_MARGIN.

Ports:
- clock, input, 1, single clock; all logic on the rising edge.
- reset, input, 1, synchronous, active-high; highest priority.
- soft_reset, input, 1, synchronous, active-high flush (time-out recovery).
- write_enb, input, 1, write request.
- read_enb, input, 1, read request.
- lfd_state, input, 1, qualifies the current write as a header byte.
- data_in, input, DATA_WIDTH, write data.
- data_out, output, DATA_WIDTH, registered read data.
- data_valid, output, 1, data_out holds a byte read on the previous cycle.
- full, output, 1, count == DEPTH.
- empty, output, 1, count == 0.
- almost_full, output, 1, count ≥ DEPTH-AF_MARGIN.
- count, output, ADDR_WIDTH+1, current occupancy.
- pkt_active, output, 1, a packet is partially read.
- packet_done, output, 1, one-cycle pulse with the last (parity) byte on data_out.
- overflow_err, output, 1, sticky: a write was attempted while full.

Behaviour:
- Priority: reset > soft_reset > normal operation. Both resets act identically:
  - wr_ptr, rd_ptr, count and pkt_remaining = 0.
  - data_out = 0; data_valid, pkt_active, packet_done and overflow_err = 0.
  - empty = 1, full = 0, almost_full = 0.
  - Memory contents are not cleared.
- Write accepted: write_enb & !full, evaluated before any same-cycle read.
  - mem[wr_ptr] <= {lfd_state, data_in}; wr_ptr increments modulo DEPTH.
- Read accepted: read_enb & !empty.
  - Next cycle: data_out <= mem[rd_ptr][DATA_WIDTH-1:0], data_valid = 1; rd_ptr increments modulo DEPTH.
  - Read latency is 1 cycle.
- No accepted read: data_valid = 0 next cycle and data_out holds its value.
  - Exception: data_out returns to 0 when pkt_active = 0 and empty = 1.
- count:
  - +1 on write-only, -1 on read-only.
  - Unchanged when both are accepted or neither is.
- Simultaneous requests at the boundaries:
  - When full, a simultaneous read+write accepts only the read; count becomes DEPTH-1.
  - When empty, a simultaneous read+write accepts only the write.
- Overflow: write_enb & full sets overflow_err; the data is dropped. overflow_err is cleared only by reset or soft_reset.
- Header format: payload_len = data[DATA_WIDTH-1:2], addr = data[1:0].
- Packet tracking (read side):
  - Reading an entry with tag = 1 loads pkt_remaining = payload_len + 1 (payload bytes plus parity) and sets pkt_active.
  - Each subsequent accepted read of a non-header entry decrements pkt_remaining.
  - On the read that brings pkt_remaining from 1 to 0: packet_done pulses together with that byte's data_valid, and pkt_active clears on the same cycle.
  - Header with payload_len = 0: the next byte (parity) completes the packet.
  - Header read while pkt_active = 1 (malformed packet): reload the counter; packet_done is not pulsed.
  - Non-header read while pkt_active = 0: data is delivered; no tracking state changes.
- The pointer wrap is transparent; ordering is preserved across any number of wraps.

Test Plan:
- Reset at time 0 with write_enb = 1 -> empty=1, full=0, count=0, data_out=8'h00, overflow_err=0, nothing written.
- Write header 8'h25 (len 9, addr 01) with lfd_state=1, then 9 payload bytes and 1 parity (count=11), then read_enb=1 for 11 cycles -> data_out sequence matches the writes one cycle after each read; pkt_active high from the header's data cycle through the 10th byte; packet_done pulses exactly once with the parity byte; then empty=1, data_out returns to 0.
- 16 writes with no reads -> almost_full=1 at count=14, full=1 at count=16; 17th write (8'hAA) dropped, overflow_err=1, count stays 16; reading 16 entries returns the original 16 bytes only.
- At count=5, hold read_enb and write_enb both high for 20 cycles -> count stays 5 throughout, pointers wrap; output order equals input order.
- soft_reset for one cycle midway through reading a 9-byte packet -> next cycle count=0, empty=1, data_out=0, pkt_active=0, overflow_err=0; a new packet with header 8'h09 (len 2) then reads correctly with packet_done on its 4th byte.
- reset and soft_reset high together with write_enb=1 on a full FIFO -> reset result (all cleared); no write and no overflow_err set.

Source files
------------

// File: rtl/fifo_router_param.sv
// Packet-aware router output FIFO: tagged header storage, one-cycle registered
// read path, packet byte tracking, fill-level flags and sticky overflow detect.
module fifo_router_param #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int AF_MARGIN  = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  soft_reset,
  input  logic                  write_enb,
  input  logic                  read_enb,
  input  logic                  lfd_state,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  pkt_active,
  output logic                  packet_done,
  output logic                  overflow_err
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int CW    = ADDR_WIDTH + 1;
  localparam int RW    = DATA_WIDTH - 1;

  logic [DATA_WIDTH:0]   r_mem [DEPTH];
  logic [ADDR_WIDTH-1:0] r_wr_ptr;
  logic [ADDR_WIDTH-1:0] r_rd_ptr;
  logic [CW-1:0]         r_count;
  logic [RW-1:0]         r_pkt_rem;
  logic [DATA_WIDTH-1:0] r_data_p1;
  logic                  r_vld_p1;
  logic                  r_pkt_active;
  logic                  r_pkt_done_p1;
  logic                  r_ovf;

  logic                  w_full;
  logic                  w_empty;
  logic                  w_flush;
  logic                  w_wr_acc;
  logic                  w_rd_acc;
  logic [DATA_WIDTH:0]   w_rd_word;
  logic                  w_rd_hdr;
  logic [RW-1:0]         w_hdr_rem;

  assign w_full    = (r_count == CW'(DEPTH));
  assign w_empty   = (r_count == '0);
  assign w_flush   = reset | soft_reset;
  // Full blocks the write and empty blocks the read, so each boundary case
  // accepts exactly one side of a simultaneous request.
  assign w_wr_acc  = write_enb & ~w_full & ~w_flush;
  assign w_rd_acc  = read_enb & ~w_empty;
  assign w_rd_word = r_mem[r_rd_ptr];
  assign w_rd_hdr  = w_rd_word[DATA_WIDTH];
  assign w_hdr_rem = {1'b0, w_rd_word[DATA_WIDTH-1:2]} + RW'(1);

  // Storage is never flushed; only the pointers and occupancy are.
  always_ff @(posedge clock) begin
    if (w_wr_acc) r_mem[r_wr_ptr] <= {lfd_state, data_in};
  end

  // Stage p0 -> p1: read data, valid and packet tracking register together.
  always_ff @(posedge clock) begin
    if (w_flush) begin
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_count       <= '0;
      r_pkt_rem     <= '0;
      r_data_p1     <= '0;
      r_vld_p1      <= 1'b0;
      r_pkt_active  <= 1'b0;
      r_pkt_done_p1 <= 1'b0;
      r_ovf         <= 1'b0;
    end else begin
      r_pkt_done_p1 <= 1'b0;
      r_vld_p1      <= w_rd_acc;
      if (write_enb && w_full) r_ovf <= 1'b1;
      if (w_wr_acc) r_wr_ptr <= r_wr_ptr + 1'b1;
      case ({w_wr_acc, w_rd_acc})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (w_rd_acc) begin
        r_rd_ptr  <= r_rd_ptr + 1'b1;
        r_data_p1 <= w_rd_word[DATA_WIDTH-1:0];
        if (w_rd_hdr) begin
          // A header mid-packet restarts tracking without completing the old one.
          r_pkt_rem    <= w_hdr_rem;
          r_pkt_active <= 1'b1;
        end else if (r_pkt_active) begin
          r_pkt_rem <= r_pkt_rem - 1'b1;
          if (r_pkt_rem == RW'(1)) begin
            r_pkt_active  <= 1'b0;
            r_pkt_done_p1 <= 1'b1;
          end
        end
      end else if (!r_pkt_active && w_empty) begin
        r_data_p1 <= '0;
      end
    end
  end

  assign data_out     = r_data_p1;
  assign data_valid   = r_vld_p1;
  assign packet_done  = r_pkt_done_p1;
  assign pkt_active   = r_pkt_active;
  assign overflow_err = r_ovf;
  assign count        = r_count;
  assign full         = w_full;
  assign empty        = w_empty;
  assign almost_full  = (r_count >= CW'(DEPTH - AF_MARGIN));

endmodule

// File: tb/tb_fifo_router_param.sv
// Directed and randomized bench for fifo_router_param against a queue-based
// behavioural model of the router FIFO.
module tb_fifo_router_param;

  logic       clock;
  logic       reset, soft_reset, write_enb, read_enb, lfd_state;
  logic [7:0] data_in, data_out;
  logic       data_valid, full, empty, almost_full;
  logic [4:0] count;
  logic       pkt_active, packet_done, overflow_err;

  int errors = 0;
  int checks = 0;

  fifo_router_param #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .AF_MARGIN(2)) dut (
    .clock(clock), .reset(reset), .soft_reset(soft_reset),
    .write_enb(write_enb), .read_enb(read_enb), .lfd_state(lfd_state),
    .data_in(data_in), .data_out(data_out), .data_valid(data_valid),
    .full(full), .empty(empty), .almost_full(almost_full), .count(count),
    .pkt_active(pkt_active), .packet_done(packet_done), .overflow_err(overflow_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference: FIFO contents as a queue of {header tag, byte}.
  logic [8:0] q[$];
  logic [7:0] m_dout;
  logic       m_vld, m_act, m_done, m_ovf;
  int         m_rem;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    logic [8:0] w;
    logic mf, me, wa, ra;
    if (reset || soft_reset) begin
      q.delete();
      m_dout = '0; m_vld = 1'b0; m_act = 1'b0; m_rem = 0; m_done = 1'b0; m_ovf = 1'b0;
      return;
    end
    mf = (q.size() == 16);
    me = (q.size() == 0);
    wa = write_enb && !mf;
    ra = read_enb && !me;
    m_done = 1'b0;
    if (write_enb && mf) m_ovf = 1'b1;
    m_vld = ra;
    if (ra) begin
      w = q.pop_front();
      m_dout = w[7:0];
      if (w[8]) begin
        m_rem = int'(w[7:2]) + 1;
        m_act = 1'b1;
      end else if (m_act) begin
        m_rem--;
        if (m_rem == 0) begin
          m_act  = 1'b0;
          m_done = 1'b1;
        end
      end
    end else if (!m_act && me) begin
      m_dout = '0;
    end
    if (wa) q.push_back({lfd_state, data_in});
  endtask

  task automatic compare_all();
    check("count",      32'(count),        32'(q.size()));
    check("empty",      32'(empty),        32'(q.size() == 0));
    check("full",       32'(full),         32'(q.size() == 16));
    check("afull",      32'(almost_full),  32'(q.size() >= 14));
    check("dout",       32'(data_out),     32'(m_dout));
    check("dvalid",     32'(data_valid),   32'(m_vld));
    check("pkt_active", 32'(pkt_active),   32'(m_act));
    check("pkt_done",   32'(packet_done),  32'(m_done));
    check("ovf",        32'(overflow_err), 32'(m_ovf));
  endtask

  task automatic drive(input logic rs, input logic sr, input logic we, input logic re,
                       input logic lfd, input logic [7:0] d);
    reset = rs; soft_reset = sr; write_enb = we; read_enb = re; lfd_state = lfd; data_in = d;
    model_step();
    @(posedge clock);
    #1;
    compare_all();
  endtask

  initial begin
    logic [7:0] pkt [11];
    logic [7:0] par;
    int done_cnt;

    reset = 1'b1; soft_reset = 1'b0; write_enb = 1'b1; read_enb = 1'b0;
    lfd_state = 1'b0; data_in = 8'h5A;
    m_dout = '0; m_vld = 1'b0; m_act = 1'b0; m_rem = 0; m_done = 1'b0; m_ovf = 1'b0;

    // Reset with a pending write: nothing may land in the FIFO.
    drive(1, 0, 1, 0, 0, 8'h5A);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_full",  32'(full), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_dout",  32'(data_out), 32'h00);
    check("rst_ovf",   32'(overflow_err), 32'd0);
    drive(0, 0, 0, 0, 0, 8'h00);
    check("rst_nowrite", 32'(count), 32'd0);

    // Header 0x25: 9 payload bytes plus parity.
    pkt[0] = 8'h25;
    par = 8'h25;
    for (int i = 1; i <= 9; i++) begin
      pkt[i] = 8'h30 + 8'(i);
      par ^= pkt[i];
    end
    pkt[10] = par;
    for (int i = 0; i < 11; i++) drive(0, 0, 1, 0, (i == 0), pkt[i]);
    check("pkt_count", 32'(count), 32'd11);
    done_cnt = 0;
    for (int i = 0; i < 11; i++) begin
      drive(0, 0, 0, 1, 0, 8'h00);
      check("pkt_byte",   32'(data_out), 32'(pkt[i]));
      check("pkt_act_d",  32'(pkt_active), 32'(i < 10));
      if (packet_done) begin
        done_cnt++;
        check("pkt_done_at_parity", 32'(i), 32'd10);
      end
    end
    check("pkt_done_once", 32'(done_cnt), 32'd1);
    drive(0, 0, 0, 0, 0, 8'h00);
    check("pkt_end_empty", 32'(empty), 32'd1);
    check("pkt_end_dout",  32'(data_out), 32'h00);

    // Fill to full, then overflow.
    for (int i = 0; i < 16; i++) begin
      drive(0, 0, 1, 0, 0, 8'h40 + 8'(i));
      if (i == 12) check("af_at13", 32'(almost_full), 32'd0);
      if (i == 13) check("af_at14", 32'(almost_full), 32'd1);
      if (i == 14) check("full_at15", 32'(full), 32'd0);
      if (i == 15) check("full_at16", 32'(full), 32'd1);
    end
    drive(0, 0, 1, 0, 0, 8'hAA);
    check("ovf_set",   32'(overflow_err), 32'd1);
    check("ovf_count", 32'(count), 32'd16);
    for (int i = 0; i < 16; i++) begin
      drive(0, 0, 0, 1, 0, 8'h00);
      check("fill_byte", 32'(data_out), 32'(8'h40 + 8'(i)));
    end
    check("fill_drained", 32'(count), 32'd0);

    // Steady simultaneous read/write at count 5 across pointer wraps.
    for (int i = 0; i < 5; i++) drive(0, 0, 1, 0, 0, 8'h50 + 8'(i));
    for (int k = 0; k < 20; k++) begin
      drive(0, 0, 1, 1, 0, 8'h60 + 8'(k));
      check("rw_count", 32'(count), 32'd5);
      check("rw_order", 32'(data_out), (k < 5) ? 32'(8'h50 + 8'(k)) : 32'(8'h60 + 8'(k - 5)));
    end
    for (int k = 0; k < 5; k++) begin
      drive(0, 0, 0, 1, 0, 8'h00);
      check("rw_drain", 32'(data_out), 32'(8'h60 + 8'(15 + k)));
    end

    // Soft reset midway through a 9-byte packet (header 0x1D, len 7).
    drive(0, 0, 1, 0, 1, 8'h1D);
    for (int i = 0; i < 8; i++) drive(0, 0, 1, 0, 0, 8'h70 + 8'(i));
    for (int i = 0; i < 4; i++) drive(0, 0, 0, 1, 0, 8'h00);
    check("sr_pre_act", 32'(pkt_active), 32'd1);
    check("sr_pre_ovf", 32'(overflow_err), 32'd1);
    drive(0, 1, 0, 0, 0, 8'h00);
    check("sr_count", 32'(count), 32'd0);
    check("sr_empty", 32'(empty), 32'd1);
    check("sr_dout",  32'(data_out), 32'h00);
    check("sr_act",   32'(pkt_active), 32'd0);
    check("sr_ovf",   32'(overflow_err), 32'd0);
    pkt[0] = 8'h09; pkt[1] = 8'hA1; pkt[2] = 8'hA2; pkt[3] = 8'h09 ^ 8'hA1 ^ 8'hA2;
    for (int i = 0; i < 4; i++) drive(0, 0, 1, 0, (i == 0), pkt[i]);
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 0, 1, 0, 8'h00);
      check("sr_pkt_byte", 32'(data_out), 32'(pkt[i]));
      check("sr_pkt_done", 32'(packet_done), 32'(i == 3));
    end

    // Both resets together against a full FIFO with a write pending.
    for (int i = 0; i < 16; i++) drive(0, 0, 1, 0, 0, 8'h80 + 8'(i));
    check("both_pre_full", 32'(full), 32'd1);
    drive(1, 1, 1, 0, 0, 8'hEE);
    check("both_count", 32'(count), 32'd0);
    check("both_empty", 32'(empty), 32'd1);
    check("both_full",  32'(full), 32'd0);
    check("both_ovf",   32'(overflow_err), 32'd0);
    check("both_dout",  32'(data_out), 32'h00);
    drive(0, 0, 0, 0, 0, 8'h00);
    check("both_nowrite", 32'(count), 32'd0);

    // Randomized traffic with occasional headers and flushes.
    for (int n = 0; n < 800; n++) begin
      drive(1'b0,
            ($urandom_range(0, 199) == 0),
            ($urandom_range(0, 99) < 55),
            ($urandom_range(0, 99) < 50),
            ($urandom_range(0, 7) == 0),
            8'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
